icache_r32i: RTL and testbench
==============================

// Module: icache_r32i
// PURPOSE
//  Direct-mapped instruction cache that receives ProgAddr from the RV32I PC and returns the 32-bit instruction.
//  On a miss it raises InsCacheStall, which freezes the PC, and refills one line from backing memory.
//  It sits between the PC/fetch stage and the instruction memory port.
// PARAMETERS
//  dataW  32  address/instruction width
//  LINES  16  number of cache lines (power of 2, >=2)
//  WORDS  4   32-bit words per line (power of 2, >=2)
// PORTS
//  clock          in   1      clock, rising edge
//  reset          in   1      asynchronous, active-high
//  ProgAddr       in   dataW  fetch address from PC; bits [1:0] ignored
//  Flush          in   1      invalidate all lines (fence.i)
//  Instruction    out  32     fetched instruction; 32'h00000013 (NOP) while stalled
//  InsCacheStall  out  1      high while ProgAddr misses or a refill is in progress
//  MemReq         out  1      refill request; held high until the last beat is accepted
//  MemAddr        out  dataW  line-aligned refill address (low log2(WORDS)+2 bits zero)
//  MemValid       in   1      one refill word present on MemData this cycle
//  MemData        in   32     refill word; beats arrive in ascending word order
// BEHAVIOUR
//  Address split: off=[1:0], word=[log2(WORDS)+1:2], index=next log2(LINES) bits, tag=rest.
//  Reset: all valid bits 0, state IDLE, beat counter 0, MemReq 0, MemAddr 0, stall pending flag 0.
//  Lookup is combinational: hit = valid[index] && tag match, in IDLE only.
//  A hit returns Instruction = data[index][word] in the same cycle with InsCacheStall=0 (zero-latency hit).
//  Any miss drives InsCacheStall=1 in the same cycle.
//  FSM states:
//   - IDLE: on a miss with Flush=0, latch index/tag, set MemReq=1, MemAddr = {ProgAddr line bits, 0}, clear counter, go to REFILL.
//   - REFILL: each MemValid beat writes data[index][counter] and increments counter. On beat WORDS-1, set tag[index] and valid[index] (unless flush pending), drop MemReq next edge, go to IDLE.
//  Gaps (MemValid=0) are legal; the counter holds during a gap.
//  MemValid while IDLE is ignored.
//  InsCacheStall stays 1 for the whole REFILL. The first hit comes the cycle after returning to IDLE.
//  Minimum miss penalty is WORDS+1 cycles.
//  ProgAddr is held stable by the PC while stalled, so the cache needs no address latch for the lookup.
//  Flush in IDLE clears all valid bits at the next edge; Instruction/stall for that cycle reflect the pre-flush lookup.
//  Flush during REFILL sets flushPend: the refill completes but the line is not validated; flushPend is cleared on exit.
//  A miss and Flush in the same IDLE cycle: the flush wins and the refill starts on the following cycle.
//  Reset mid-refill: FSM returns to IDLE, MemReq drops immediately, and all lines are invalid.
//  ProgAddr arithmetic wraps modulo 2^dataW; no special casing.
// CONFIGURATION
//  ICACHE_STATS_EN defined: adds outputs HitCount[31:0] and MissCount[31:0], reset to 0.
//   - HitCount increments on each IDLE-cycle hit.
//   - MissCount increments on each IDLE->REFILL transition.
//   - Both wrap at 2^32, and both are cleared by reset only (not by Flush).
//  ICACHE_STATS_EN undefined: the ports and counters are absent; the rest of the behaviour is identical.
// STRUCTURE
//  Package r32i_icache_pkg holds:
//   - typedef enum logic {IDLE, REFILL} icache_state_t
//   - localparam NOP_INSTR = 32'h00000013
//   - function that derives index/word/tag widths from LINES/WORDS
//  Sub-module icache_store_r32i holds the data/tag/valid arrays.
//   - Async read port; sync write port with line/word select.
//   - Bulk valid-clear input driven by Flush and reset.
//  FSM, beat counter and handshake live in icache_r32i.
// TESTING
//  1. Cold miss (defaults): ProgAddr=0x0 -> stall=1 same cycle; next edge MemReq=1, MemAddr=0x0.
//     Feed beats 0x11,0x22,0x33,0x44 -> stall drops the cycle after beat 4; ProgAddr=0x8 returns 0x33 with no stall.
//  2. Conflict: after (1), ProgAddr=0x100 (same index 0, new tag) -> miss, MemAddr=0x100.
//     Refill 0xA0..0xA3 -> then ProgAddr=0x0 misses again.
//  3. Beat gaps: MemValid pattern 1,0,0,1,0,1,1 -> exactly 4 words written in order; stall is released only after the 4th beat.
//  4. Reset after 2 beats: MemReq=0 immediately, stall=1 on the next lookup of 0x0, and a fresh refill restarts at word 0.
//  5. Flush during refill: Flush pulse at beat 2 -> refill finishes, then the same ProgAddr misses again.
//     Flush in IDLE after a hit -> the next access misses.
//  6. ICACHE_STATS_EN: run (1), then 3 hits -> MissCount=1, HitCount=3; after reset both read 0.

Source files
------------

// File: rtl/r32i_icache_pkg.sv
// Shared types and width helpers for the RV32I instruction cache.
// Holds the FSM state enum, the NOP filler word and address-split widths.
package r32i_icache_pkg;

  typedef enum logic {IDLE, REFILL} icache_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  function automatic int log2i(input int n);
    return $clog2(n);
  endfunction

  function automatic int tag_w(
    input int aw,
    input int lines,
    input int words
  );
    return aw - log2i(lines) - log2i(words) - 2;
  endfunction

endpackage

// File: rtl/icache_store_r32i.sv
// Data/tag/valid arrays of the instruction cache.
// Ports: clock, reset (async, clears valid), clear (sync bulk valid clear),
//   rd_line/rd_word -> rd_data/rd_tag/rd_valid (async read),
//   wr_en/wr_line/wr_word/wr_data (word write), set_en/set_tag (validate line).
module icache_store_r32i
  import r32i_icache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int WORDS = 4,
  parameter int TW    = 24,
  parameter int IB    = log2i(LINES),
  parameter int WB    = log2i(WORDS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic [IB-1:0] rd_line,
  input  logic [WB-1:0] rd_word,
  output logic [31:0]   rd_data,
  output logic [TW-1:0] rd_tag,
  output logic          rd_valid,
  input  logic          wr_en,
  input  logic [IB-1:0] wr_line,
  input  logic [WB-1:0] wr_word,
  input  logic [31:0]   wr_data,
  input  logic          set_en,
  input  logic [TW-1:0] set_tag
);

  logic [31:0]      data [LINES][WORDS];
  logic [TW-1:0]    tags [LINES];
  logic [LINES-1:0] valid;

  assign rd_data  = data[rd_line][rd_word];
  assign rd_tag   = tags[rd_line];
  assign rd_valid = valid[rd_line];

  always_ff @(posedge clock) begin
    if (wr_en)
      data[wr_line][wr_word] <= wr_data;
    if (set_en)
      tags[wr_line] <= set_tag;
  end

  // Clear has priority so a flush on the final beat leaves the line invalid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      valid <= '0;
    else if (clear)
      valid <= '0;
    else if (set_en)
      valid[wr_line] <= 1'b1;
  end

endmodule

// File: rtl/icache_r32i.sv
// Direct-mapped RV32I instruction cache with zero-latency hits and line refill.
// Ports: clock, reset (async high), ProgAddr, Flush -> Instruction, InsCacheStall;
//   refill: MemReq, MemAddr out, MemValid, MemData in.
// Macro ICACHE_STATS_EN adds HitCount/MissCount outputs.
module icache_r32i
  import r32i_icache_pkg::*;
#(
  parameter int dataW = 32,
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [dataW-1:0] ProgAddr,
  input  logic             Flush,
  output logic [31:0]      Instruction,
  output logic             InsCacheStall,
  output logic             MemReq,
  output logic [dataW-1:0] MemAddr,
  input  logic             MemValid,
  input  logic [31:0]      MemData
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]      HitCount,
  output logic [31:0]      MissCount
`endif
);

  localparam int WB = log2i(WORDS);
  localparam int IB = log2i(LINES);
  localparam int LO = WB + 2;
  localparam int TW = tag_w(dataW, LINES, WORDS);

  icache_state_t state;
  logic [WB-1:0] cnt;
  logic [IB-1:0] line_q;
  logic [TW-1:0] tag_q;
  logic          flushPend;

  logic [WB-1:0] a_word;
  logic [IB-1:0] a_line;
  logic [TW-1:0] a_tag;
  logic [31:0]   rd_data;
  logic [TW-1:0] rd_tag;
  logic          rd_valid;
  logic          hit;
  logic          miss;
  logic          wr_en;
  logic          last;
  logic          set_en;
  logic          unused;

  assign a_word = ProgAddr[LO-1:2];
  assign a_line = ProgAddr[IB+LO-1:LO];
  assign a_tag  = ProgAddr[dataW-1:IB+LO];
  assign unused = ^ProgAddr[1:0];

  always_comb begin
    hit    = (state == IDLE) && rd_valid
          && (rd_tag == a_tag);
    miss   = (state == IDLE) && !hit;
    wr_en  = (state == REFILL) && MemValid;
    last   = wr_en && (cnt == WB'(WORDS - 1));
    // A flush arriving on the final beat must also block validation.
    set_en = last && !flushPend && !Flush;
    Instruction   = hit ? rd_data : NOP_INSTR;
    InsCacheStall = !hit;
  end

  icache_store_r32i #(
    .LINES (LINES),
    .WORDS (WORDS),
    .TW    (TW),
    .IB    (IB),
    .WB    (WB)
  ) u_store (
    .clock    (clock),
    .reset    (reset),
    .clear    (Flush),
    .rd_line  (a_line),
    .rd_word  (a_word),
    .rd_data  (rd_data),
    .rd_tag   (rd_tag),
    .rd_valid (rd_valid),
    .wr_en    (wr_en),
    .wr_line  (line_q),
    .wr_word  (cnt),
    .wr_data  (MemData),
    .set_en   (set_en),
    .set_tag  (tag_q)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      line_q    <= '0;
      tag_q     <= '0;
      flushPend <= 1'b0;
      MemReq    <= 1'b0;
      MemAddr   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (miss && !Flush) begin
            state   <= REFILL;
            line_q  <= a_line;
            tag_q   <= a_tag;
            cnt     <= '0;
            MemReq  <= 1'b1;
            MemAddr <= {ProgAddr[dataW-1:LO],
                        {LO{1'b0}}};
          end
        end
        REFILL: begin
          if (Flush)
            flushPend <= 1'b1;
          if (wr_en)
            cnt <= cnt + 1'b1;
          if (last) begin
            state     <= IDLE;
            MemReq    <= 1'b0;
            flushPend <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      HitCount  <= '0;
      MissCount <= '0;
    end else begin
      if (hit)
        HitCount <= HitCount + 32'd1;
      if (miss && !Flush)
        MissCount <= MissCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_r32i.sv
// Scoreboard bench for icache_r32i: refill words are queued as they are
// served, then popped and compared when the cache returns them on hits.
module tb_icache_r32i;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        Flush = 1'b0;
  logic        MemValid = 1'b0;
  logic [31:0] ProgAddr = '0;
  logic [31:0] MemData = '0;
  logic [31:0] Instruction;
  logic [31:0] MemAddr;
  logic        InsCacheStall;
  logic        MemReq;
`ifdef ICACHE_STATS_EN
  logic [31:0] HitCount;
  logic [31:0] MissCount;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } sb_t;
  sb_t sb[$];
  sb_t e;

  localparam logic [31:0] NOP = 32'h00000013;

  icache_r32i dut (
    .clock         (clock),
    .reset         (reset),
    .ProgAddr      (ProgAddr),
    .Flush         (Flush),
    .Instruction   (Instruction),
    .InsCacheStall (InsCacheStall),
    .MemReq        (MemReq),
    .MemAddr       (MemAddr),
    .MemValid      (MemValid),
    .MemData       (MemData)
`ifdef ICACHE_STATS_EN
    ,
    .HitCount      (HitCount),
    .MissCount     (MissCount)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [127:0] mkline(input logic [31:0] s);
    return {s + 32'd3, s + 32'd2, s + 32'd1, s};
  endfunction

  task automatic apply_reset();
    reset = 1'b1;
    ProgAddr = '0;
    Flush = 1'b0;
    MemValid = 1'b0;
    sb.delete();
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  // Present a missing address and wait (bounded) for the refill request.
  task automatic start_miss(input logic [31:0] addr);
    int n;
    n = 0;
    ProgAddr = addr;
    Flush = 1'b0;
    MemValid = 1'b0;
    while (MemReq !== 1'b1 && n < 16) begin
      cyc();
      n++;
    end
    checks++;
    if (MemReq !== 1'b1) begin
      failures++;
      $display("FAIL memreq_timeout addr=%h got=%b want=1", addr, MemReq);
    end
  endtask

  // Serve one line, optionally with idle gaps before each beat.
  task automatic feed(
    input logic [31:0]  base,
    input logic [127:0] ln,
    input int           gaps
  );
    for (int i = 0; i < 4; i++) begin
      repeat (gaps) begin
        MemValid = 1'b0;
        MemData = 32'hDEADBEEF;
        cyc();
      end
      MemValid = 1'b1;
      MemData = ln[32*i +: 32];
      sb.push_back('{base + 32'(4 * i), ln[32*i +: 32]});
      cyc();
    end
    MemValid = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++;
    if (MemReq !== 1'b0 || MemAddr !== 32'h0) begin
      failures++;
      $display("FAIL reset_mem got req=%b addr=%h want 0/0", MemReq, MemAddr);
    end
    checks++;
    if (InsCacheStall !== 1'b1 || Instruction !== NOP) begin
      failures++;
      $display("FAIL reset_lookup got stall=%b ins=%h want 1/%h",
               InsCacheStall, Instruction, NOP);
    end
  endtask

  task automatic test_cold_miss();
    logic [127:0] ln;
    ln = {32'h44, 32'h33, 32'h22, 32'h11};
    ProgAddr = 32'h0;
    #1;
    checks++;
    if (InsCacheStall !== 1'b1 || Instruction !== NOP) begin
      failures++;
      $display("FAIL cold_stall got stall=%b ins=%h want 1/nop",
               InsCacheStall, Instruction);
    end
    cyc();
    checks++;
    if (MemReq !== 1'b1 || MemAddr !== 32'h0) begin
      failures++;
      $display("FAIL cold_req got req=%b addr=%h want 1/0", MemReq, MemAddr);
    end
    for (int i = 0; i < 4; i++) begin
      MemValid = 1'b1;
      MemData = ln[32*i +: 32];
      sb.push_back('{32'(4 * i), ln[32*i +: 32]});
      #1;
      checks++;
      if (InsCacheStall !== 1'b1) begin
        failures++;
        $display("FAIL cold_beat_stall beat=%0d got=%b want=1", i, InsCacheStall);
      end
      cyc();
    end
    MemValid = 1'b0;
    #1;
    checks++;
    if (MemReq !== 1'b0 || InsCacheStall !== 1'b0 || Instruction !== 32'h11) begin
      failures++;
      $display("FAIL cold_done got req=%b stall=%b ins=%h want 0/0/11",
               MemReq, InsCacheStall, Instruction);
    end
    ProgAddr = 32'h8;
    #1;
    checks++;
    if (InsCacheStall !== 1'b0 || Instruction !== 32'h33) begin
      failures++;
      $display("FAIL cold_hit8 got stall=%b ins=%h want 0/33",
               InsCacheStall, Instruction);
    end
    cyc();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      ProgAddr = e.a;
      #1;
      checks++;
      if (Instruction !== e.d || InsCacheStall !== 1'b0) begin
        failures++;
        $display("FAIL cold_sb addr=%h got=%h stall=%b want=%h",
                 e.a, Instruction, InsCacheStall, e.d);
      end
      cyc();
    end
  endtask

  task automatic test_conflict();
    ProgAddr = 32'h100;
    #1;
    checks++;
    if (InsCacheStall !== 1'b1) begin
      failures++;
      $display("FAIL conf_stall got=%b want=1", InsCacheStall);
    end
    cyc();
    checks++;
    if (MemReq !== 1'b1 || MemAddr !== 32'h100) begin
      failures++;
      $display("FAIL conf_req got req=%b addr=%h want 1/100", MemReq, MemAddr);
    end
    feed(32'h100, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      ProgAddr = e.a;
      #1;
      checks++;
      if (Instruction !== e.d || InsCacheStall !== 1'b0) begin
        failures++;
        $display("FAIL conf_sb addr=%h got=%h stall=%b want=%h",
                 e.a, Instruction, InsCacheStall, e.d);
      end
      cyc();
    end
    ProgAddr = 32'h0;
    #1;
    checks++;
    if (InsCacheStall !== 1'b1 || Instruction !== NOP) begin
      failures++;
      $display("FAIL conf_evict got stall=%b ins=%h want 1/nop",
               InsCacheStall, Instruction);
    end
    start_miss(32'h0);
    feed(32'h0, {32'h44, 32'h33, 32'h22, 32'h11}, 0);
    sb.delete();
  endtask

  task automatic test_gaps();
    int pat[7] = '{1, 0, 0, 1, 0, 1, 1};
    int k;
    logic [127:0] ln;
    ln = mkline(32'h5000);
    k = 0;
    start_miss(32'h2040);
    checks++;
    if (MemAddr !== 32'h2040) begin
      failures++;
      $display("FAIL gap_addr got=%h want=2040", MemAddr);
    end
    for (int j = 0; j < 7; j++) begin
      MemValid = pat[j][0];
      if (pat[j] == 1) begin
        MemData = ln[32*k +: 32];
        sb.push_back('{32'h2040 + 32'(4 * k), ln[32*k +: 32]});
        k++;
      end else begin
        MemData = 32'hBAD00000 | 32'(j);
      end
      #1;
      checks++;
      if (InsCacheStall !== 1'b1) begin
        failures++;
        $display("FAIL gap_stall slot=%0d got=%b want=1", j, InsCacheStall);
      end
      cyc();
    end
    MemValid = 1'b0;
    #1;
    checks++;
    if (InsCacheStall !== 1'b0 || MemReq !== 1'b0) begin
      failures++;
      $display("FAIL gap_release got stall=%b req=%b want 0/0",
               InsCacheStall, MemReq);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      ProgAddr = e.a;
      #1;
      checks++;
      if (Instruction !== e.d || InsCacheStall !== 1'b0) begin
        failures++;
        $display("FAIL gap_sb addr=%h got=%h stall=%b want=%h",
                 e.a, Instruction, InsCacheStall, e.d);
      end
      cyc();
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    start_miss(32'h0);
    MemValid = 1'b1;
    MemData = 32'hC0;
    cyc();
    MemData = 32'hC1;
    cyc();
    reset = 1'b1;
    MemValid = 1'b0;
    #1;
    checks++;
    if (MemReq !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_req got=%b want=0", MemReq);
    end
    cyc();
    reset = 1'b0;
    ProgAddr = 32'h0;
    #1;
    checks++;
    if (InsCacheStall !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_stall got=%b want=1", InsCacheStall);
    end
    start_miss(32'h0);
    checks++;
    if (MemAddr !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid_addr got=%h want=0", MemAddr);
    end
    feed(32'h0, mkline(32'hD0), 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      ProgAddr = e.a;
      #1;
      checks++;
      if (Instruction !== e.d || InsCacheStall !== 1'b0) begin
        failures++;
        $display("FAIL rst_mid_sb addr=%h got=%h stall=%b want=%h",
                 e.a, Instruction, InsCacheStall, e.d);
      end
      cyc();
    end
  endtask

  task automatic test_flush();
    logic [127:0] la;
    logic [127:0] lb;
    la = mkline(32'h7700);
    lb = mkline(32'h8800);
    start_miss(32'h40);
    MemValid = 1'b1;
    MemData = 32'hE0;
    cyc();
    MemData = 32'hE1;
    cyc();
    MemData = 32'hE2;
    Flush = 1'b1;
    cyc();
    Flush = 1'b0;
    MemData = 32'hE3;
    cyc();
    MemValid = 1'b0;
    #1;
    checks++;
    if (InsCacheStall !== 1'b1 || MemReq !== 1'b0) begin
      failures++;
      $display("FAIL flush_refill got stall=%b req=%b want 1/0",
               InsCacheStall, MemReq);
    end
    start_miss(32'h40);
    feed(32'h40, la, 1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      ProgAddr = e.a;
      #1;
      checks++;
      if (Instruction !== e.d || InsCacheStall !== 1'b0) begin
        failures++;
        $display("FAIL flush_sb addr=%h got=%h stall=%b want=%h",
                 e.a, Instruction, InsCacheStall, e.d);
      end
      cyc();
    end
    ProgAddr = 32'h40;
    Flush = 1'b1;
    #1;
    checks++;
    if (InsCacheStall !== 1'b0 || Instruction !== la[31:0]) begin
      failures++;
      $display("FAIL flush_idle_pre got stall=%b ins=%h want 0/%h",
               InsCacheStall, Instruction, la[31:0]);
    end
    cyc();
    Flush = 1'b0;
    #1;
    checks++;
    if (InsCacheStall !== 1'b1) begin
      failures++;
      $display("FAIL flush_idle_miss got=%b want=1", InsCacheStall);
    end
    Flush = 1'b1;
    cyc();
    checks++;
    if (MemReq !== 1'b0) begin
      failures++;
      $display("FAIL miss_flush_wins got req=%b want=0", MemReq);
    end
    Flush = 1'b0;
    cyc();
    checks++;
    if (MemReq !== 1'b1 || MemAddr !== 32'h40) begin
      failures++;
      $display("FAIL flush_then_refill got req=%b addr=%h want 1/40",
               MemReq, MemAddr);
    end
    feed(32'h40, lb, 0);
    sb.delete();
    ProgAddr = 32'h44;
    MemValid = 1'b1;
    MemData = 32'hFFFFFFFF;
    cyc();
    cyc();
    MemValid = 1'b0;
    #1;
    checks++;
    if (InsCacheStall !== 1'b0 || Instruction !== lb[63:32]) begin
      failures++;
      $display("FAIL idle_valid got stall=%b ins=%h want 0/%h",
               InsCacheStall, Instruction, lb[63:32]);
    end
  endtask

`ifdef ICACHE_STATS_EN
  task automatic test_stats();
    apply_reset();
    start_miss(32'h0);
    feed(32'h0, {32'h44, 32'h33, 32'h22, 32'h11}, 0);
    sb.delete();
    for (int i = 0; i < 3; i++) begin
      ProgAddr = 32'(4 * i);
      cyc();
    end
    checks++;
    if (HitCount !== 32'd3 || MissCount !== 32'd1) begin
      failures++;
      $display("FAIL stats_count got hit=%0d miss=%0d want 3/1",
               HitCount, MissCount);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (HitCount !== 32'd0 || MissCount !== 32'd0) begin
      failures++;
      $display("FAIL stats_reset got hit=%0d miss=%0d want 0/0",
               HitCount, MissCount);
    end
    cyc();
    reset = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_cold_miss();
    test_conflict();
    test_gaps();
    test_reset_mid();
    test_flush();
`ifdef ICACHE_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
